// File: rtl/parity_pkg.sv
// Shared parity-mode constants and the parity-bit helper used by both codec paths.
package parity_pkg;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Widest vector the helper accepts; callers zero-extend, which leaves the XOR unchanged.
    localparam int unsigned MAX_W = 64;

    // Returns the bit that makes {bit, vec} satisfy the mode. Applied to a whole received
    // frame it is 1 exactly when that frame violates the mode.
    function automatic logic par_bit(input logic [MAX_W-1:0] vec, input logic mode);
        return (^vec) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/parity_pipe_reg.sv
// One-stage valid/ready register: full throughput, no combinational valid path.
module parity_pipe_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    logic             valid_q;
    logic [Width-1:0] data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/parity_stream_codec.sv
// Streaming odd/even parity generator and checker with saturating error/frame statistics.
module parity_stream_codec
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              odd_mode_i,
    input  logic              gen_in_valid_i,
    output logic              gen_in_ready_o,
    input  logic [DATA_W-1:0] gen_in_data_i,
    output logic              gen_out_valid_o,
    input  logic              gen_out_ready_i,
    output logic [DATA_W:0]   gen_out_frame_o,
    input  logic              chk_in_valid_i,
    output logic              chk_in_ready_o,
    input  logic [DATA_W:0]   chk_in_frame_i,
    output logic              chk_out_valid_o,
    input  logic              chk_out_ready_i,
    output logic [DATA_W-1:0] chk_out_data_o,
    output logic              chk_out_err_o,
    input  logic              stat_clr_i,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [CNT_W-1:0]  frame_cnt_o,
    output logic              err_sticky_o
);

    logic [DATA_W:0] gen_frame;
    logic            chk_err;
    logic [DATA_W:0] chk_word_in;
    logic [DATA_W:0] chk_word_out;
    logic            chk_acc;

    assign gen_frame   = {par_bit(MAX_W'(gen_in_data_i), odd_mode_i), gen_in_data_i};
    assign chk_err     = par_bit(MAX_W'(chk_in_frame_i), odd_mode_i);
    assign chk_word_in = {chk_err, chk_in_frame_i[DATA_W-1:0]};

    parity_pipe_reg #(
        .Width (DATA_W + 1)
    ) u_gen_reg (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (gen_in_valid_i),
        .in_ready_o  (gen_in_ready_o),
        .in_data_i   (gen_frame),
        .out_valid_o (gen_out_valid_o),
        .out_ready_i (gen_out_ready_i),
        .out_data_o  (gen_out_frame_o)
    );

    parity_pipe_reg #(
        .Width (DATA_W + 1)
    ) u_chk_reg (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (chk_in_valid_i),
        .in_ready_o  (chk_in_ready_o),
        .in_data_i   (chk_word_in),
        .out_valid_o (chk_out_valid_o),
        .out_ready_i (chk_out_ready_i),
        .out_data_o  (chk_word_out)
    );

    assign chk_out_err_o  = chk_word_out[DATA_W];
    assign chk_out_data_o = chk_word_out[DATA_W-1:0];
    assign chk_acc        = chk_in_valid_i && chk_in_ready_o;

    logic [CNT_W-1:0] err_cnt_q, err_cnt_d, err_base;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, frame_base;
    logic             sticky_q, sticky_d;

    // Clear takes effect first so a beat accepted on the clearing edge still counts.
    always_comb begin
        err_base    = stat_clr_i ? '0 : err_cnt_q;
        frame_base  = stat_clr_i ? '0 : frame_cnt_q;
        err_cnt_d   = err_base;
        frame_cnt_d = frame_base;
        sticky_d    = stat_clr_i ? 1'b0 : sticky_q;
        if (chk_acc) begin
            if (frame_base != {CNT_W{1'b1}}) begin
                frame_cnt_d = frame_base + CNT_W'(1);
            end
            if (chk_err) begin
                sticky_d = 1'b1;
                if (err_base != {CNT_W{1'b1}}) begin
                    err_cnt_d = err_base + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q   <= '0;
            frame_cnt_q <= '0;
            sticky_q    <= 1'b0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            sticky_q    <= sticky_d;
        end
    end

    assign err_cnt_o    = err_cnt_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign err_sticky_o = sticky_q;

endmodule

// File: doc/parity_stream_codec.md
# parity_stream_codec

Parametrised odd/even parity generator and checker with valid/ready streaming on both paths, a registered output stage per path, and error/frame statistics. It generalises the 4-bit combinational odd-parity pair into a DATA_W-wide, runtime-selectable-mode, back-pressure-aware block. It sits between a message producer and a link (generator path), and between the link and a consumer (checker path).

## Interface
- DATA_W, default 4: payload width in bits; frame width is DATA_W+1.
- CNT_W, default 8: width of the error and frame counters.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- odd_mode  in  1  1 = odd parity, 0 = even parity; sampled per beat at acceptance.
- gen_in_valid  in  1  generator input beat valid.
- gen_in_ready  out  1  generator input may be accepted.
- gen_in_data  in  DATA_W  payload to encode.
- gen_out_valid  out  1  encoded frame valid.
- gen_out_ready  in  1  downstream accepts the frame.
- gen_out_frame  out  DATA_W+1  {parity, payload}; parity at MSB.
- chk_in_valid  in  1  received frame valid.
- chk_in_ready  out  1  checker input may be accepted.
- chk_in_frame  in  DATA_W+1  {parity, payload} to check.
- chk_out_valid  out  1  check result valid.
- chk_out_ready  in  1  consumer accepts the result.
- chk_out_data  out  DATA_W  payload field of the checked frame.
- chk_out_err  out  1  parity error on this frame.
- stat_clr  in  1  synchronous clear of statistics.
- err_cnt  out  CNT_W  saturating count of erroneous frames.
- frame_cnt  out  CNT_W  saturating count of checked frames.
- err_sticky  out  1  set by any error, cleared only by stat_clr or reset.

## Operation
- Beat transfer on an interface = valid & ready high at the same rising edge; valid, once high, holds its data stable until accepted.
- Generator: on acceptance, parity p = ^gen_in_data when odd_mode=0, p = ~^gen_in_data when odd_mode=1; gen_out_frame <= {p, gen_in_data}.
- Checker: x = ^chk_in_frame; error = (x==0) when odd_mode=1, error = (x==1) when odd_mode=0; chk_out_data <= chk_in_frame[DATA_W-1:0], chk_out_err <= error.
- Each path is one pipeline register: in_ready = !out_valid | out_ready (full throughput, no combinational path from in_valid to out_valid).
- Statistics update on checker input acceptance: frame_cnt += 1; if error, err_cnt += 1 and err_sticky <= 1. Both counters saturate at all-ones, never wrap.
- stat_clr same cycle as an accepted checker beat: clear applies first, then that beat counts (frame_cnt=1, err_cnt=error, err_sticky=error).
- Changing odd_mode affects only beats accepted at or after the change; registered outputs are not recomputed.
- The two paths are independent; simultaneous activity on both is normal.

## Timing
- Reset values: gen_out_valid=0, gen_out_frame=0, chk_out_valid=0, chk_out_data=0, chk_out_err=0, err_cnt=0, frame_cnt=0, err_sticky=0; gen_in_ready and chk_in_ready read 1 during and after reset.
- Latency: 1 cycle from input acceptance to out_valid high with result.
- Back-pressure: out_ready low with out_valid high -> in_ready low, output stable; out_ready high -> new beat may be accepted the same edge (back-to-back, one beat per cycle).
- Reset asserted mid-transfer: pending beats discarded, counters cleared immediately, no output beat after release until a new input is accepted.
- err_cnt/frame_cnt/err_sticky visible one edge after the accepting edge.

## Structure
- Package parity_pkg: parity-mode constants (PAR_EVEN=0, PAR_ODD=1) and a function computing the parity bit for a given vector and mode; used by both paths.
- Sub-module parity_pipe_reg: parametrised one-stage valid/ready register (width param), instantiated once per path.
- Top holds parity logic, statistics counters and sticky flag.

## Test plan
- odd_mode=1, gen_in_data=4'b1010 then 4'b1110, gen_out_ready=1 -> gen_out_frame=5'b11010 then 5'b01110, one cycle after each acceptance.
- odd_mode=1, chk_in_frame=5'b01010 -> chk_out_err=1, chk_out_data=4'b1010, err_cnt=1, err_sticky=1; then 5'b11010 -> err=0, frame_cnt=2, err_cnt=1.
- odd_mode=0, gen_in_data=4'b1010 -> 5'b01010; feed to checker in even mode -> chk_out_err=0.
- Hold gen_out_ready=0 for 3 cycles with gen_in_valid=1 -> first frame held stable, gen_in_ready=0; release -> frames delivered in order, no loss or duplication.
- CNT_W=2, 5 erroneous frames -> err_cnt saturates at 3; stat_clr coincident with 6th error -> err_cnt=1, frame_cnt=1.
- rst_n pulsed low while both output stages full -> all outputs and counters 0 asynchronously, in_ready=1.
